// File: rtl/mips_cache_pkg.sv
// Shared types for the data-cache miss/write-through controller.
// State encoding and the bus word-alignment mask.
package mips_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        FILL,
        WR_REQ
    } cc_state_t;

    localparam logic [31:0] WORD_ALIGN = 32'hFFFF_FFFC;

endpackage

// File: rtl/mips_cache_controller_if.sv
// Avalon-MM style memory bus between the cache controller and the arbiter.
// master drives requests, slave answers with waitrequest and read data.
interface mips_cache_controller_if;

    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    modport master (
        output mem_address,
        output mem_read,
        output mem_write,
        output mem_writedata,
        output mem_byteenable,
        input  mem_waitrequest,
        input  mem_readdata,
        input  mem_readdatavalid
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        input  mem_write,
        input  mem_writedata,
        input  mem_byteenable,
        output mem_waitrequest,
        output mem_readdata,
        output mem_readdatavalid
    );

endinterface

// File: rtl/mips_cache_controller.sv
// Miss-side responder for the data cache: single-word fills over the bus
// plus a one-entry write-through store buffer, with an optional read watchdog.
module mips_cache_controller
    import mips_cache_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 0,
    parameter int WD_BITS         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] data_addr,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] writedata,
    input  logic [3:0]  byte_en,
    output logic [31:0] data_in,
    output logic        data_valid,
    output logic        busy,
    output logic        err,
    mips_cache_controller_if.master bus
);

    localparam logic [WD_BITS-1:0] WD_LAST =
        WD_BITS'(WATCHDOG_CYCLES == 0 ? 0 : WATCHDOG_CYCLES - 1);

    cc_state_t state_q, state_d;

    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [31:0]        data_in_q;
    logic               err_q;
    logic [WD_BITS-1:0] wd_cnt_q;

    logic ld_rd;
    logic ld_wr;
    logic wd_hit;
    logic wd_abort;

    assign wd_hit = (WATCHDOG_CYCLES != 0) && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d  = state_q;
        ld_rd    = 1'b0;
        ld_wr    = 1'b0;
        wd_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A miss wins over a write hit; a write miss fills first.
                if (stall && (read_en || write_en)) begin
                    ld_rd   = 1'b1;
                    state_d = RD_REQ;
                end else if (write_en && !stall) begin
                    ld_wr   = 1'b1;
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                if (!bus.mem_waitrequest) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.mem_readdatavalid) begin
                    state_d = FILL;
                end else if (wd_hit) begin
                    wd_abort = 1'b1;
                    state_d  = IDLE;
                end
            end
            FILL: state_d = IDLE;
            WR_REQ: begin
                if (!bus.mem_waitrequest) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            data_in_q <= '0;
            err_q     <= 1'b0;
            wd_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ld_rd || ld_wr) addr_q <= data_addr & WORD_ALIGN;
            if (ld_wr) begin
                wdata_q <= writedata;
                be_q    <= byte_en;
            end
            // Only a response to our own outstanding read may load the fill word.
            if (state_q == RD_WAIT && bus.mem_readdatavalid)
                data_in_q <= bus.mem_readdata;
            if (wd_abort) err_q <= 1'b1;
            if (state_q == RD_WAIT) wd_cnt_q <= wd_cnt_q + 1'b1;
            else                    wd_cnt_q <= '0;
        end
    end

    assign data_in    = data_in_q;
    assign data_valid = (state_q == FILL);
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

    assign bus.mem_address    = addr_q;
    assign bus.mem_read       = (state_q == RD_REQ);
    assign bus.mem_write      = (state_q == WR_REQ);
    assign bus.mem_writedata  = wdata_q;
    assign bus.mem_byteenable = (state_q == RD_REQ) ? 4'hF :
                                (state_q == WR_REQ) ? be_q : 4'h0;

endmodule

// File: tb/tb_mips_cache_controller.sv
// Bench for mips_cache_controller: bus slave model plus scoreboard of
// expected bus operations and fill words, checked as the DUT produces them.
module tb_mips_cache_controller;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } op_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] data_addr;
    logic        read_en;
    logic        write_en;
    logic [31:0] writedata;
    logic [3:0]  byte_en;
    logic [31:0] data_in;
    logic        data_valid;
    logic        busy;
    logic        err;

    mips_cache_controller_if bus ();

    mips_cache_controller #(
        .WATCHDOG_CYCLES(4),
        .WD_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .data_addr(data_addr),
        .read_en(read_en),
        .write_en(write_en),
        .writedata(writedata),
        .byte_en(byte_en),
        .data_in(data_in),
        .data_valid(data_valid),
        .busy(busy),
        .err(err),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    op_t         exp_ops[$];
    logic [31:0] exp_fill[$];

    int          cyc = 0;
    int          acc_cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          fill_cnt = 0;
    int          hold = 0;
    int          last_hold = 0;
    int          wait_cfg = 0;
    int          wait_left = 0;
    bit          in_req = 0;
    bit          pend = 0;
    bit          respond_en = 1;
    bit          inject_rdv = 0;
    bit          unstable = 0;
    logic [31:0] rdata_cfg = '0;
    logic [31:0] inj_data = '0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus slave model and scoreboard; evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin
        op_t e;
        logic [31:0] f;
        cyc++;
        bus.mem_readdatavalid = 1'b0;
        if (rst) pend = 1'b0;
        if (pend || inject_rdv) begin
            bus.mem_readdatavalid = 1'b1;
            bus.mem_readdata = inject_rdv ? inj_data : rdata_cfg;
            pend = 1'b0;
            inject_rdv = 1'b0;
        end
        if (!rst && (bus.mem_read || bus.mem_write)) begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_left = wait_cfg;
                req_addr  = bus.mem_address;
                req_be    = bus.mem_byteenable;
                hold      = 0;
            end
            hold++;
            if (bus.mem_address !== req_addr || bus.mem_byteenable !== req_be)
                unstable = 1'b1;
            if (wait_left > 0) begin
                bus.mem_waitrequest = 1'b1;
                wait_left--;
            end else begin
                bus.mem_waitrequest = 1'b0;
                in_req    = 1'b0;
                last_hold = hold;
                checks++;
                if (exp_ops.size() == 0) begin
                    errors++;
                    $display("FAIL bus_op unexpected wr=%0b addr=%h",
                             bus.mem_write, bus.mem_address);
                end else begin
                    e = exp_ops.pop_front();
                    if (bus.mem_write !== e.wr || bus.mem_address !== e.addr ||
                        (e.wr && (bus.mem_writedata !== e.data ||
                                  bus.mem_byteenable !== e.be)) ||
                        (!e.wr && bus.mem_byteenable !== 4'hF)) begin
                        errors++;
                        $display("FAIL bus_op got wr=%0b a=%h d=%h be=%h need wr=%0b a=%h d=%h be=%h",
                                 bus.mem_write, bus.mem_address, bus.mem_writedata,
                                 bus.mem_byteenable, e.wr, e.addr, e.data, e.be);
                    end
                end
                if (bus.mem_read) begin
                    rd_cnt++;
                    acc_cyc = cyc;
                    if (respond_en) pend = 1'b1;
                end else begin
                    wr_cnt++;
                end
            end
        end else begin
            bus.mem_waitrequest = 1'b0;
            in_req = 1'b0;
        end
        if (data_valid) begin
            fill_cnt++;
            checks++;
            if (exp_fill.size() == 0) begin
                errors++;
                $display("FAIL fill unexpected data_in=%h", data_in);
            end else begin
                f = exp_fill.pop_front();
                if (data_in !== f) begin
                    errors++;
                    $display("FAIL fill data_in=%h need %h", data_in, f);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fill(output bit seen, output int n);
        seen = 1'b0;
        for (n = 0; n < 30 && !seen; n++) begin
            tick();
            if (data_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({data_in, data_valid, busy, err, bus.mem_read, bus.mem_write,
             bus.mem_address, bus.mem_writedata, bus.mem_byteenable} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b err=%b rd=%b wr=%b addr=%h need all 0",
                     busy, err, bus.mem_read, bus.mem_write, bus.mem_address);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b rd=%b wr=%b need 0", busy,
                     bus.mem_read, bus.mem_write);
        end
    endtask

    task automatic test_read_miss();
        int  f0 = fill_cnt;
        int  n;
        bit  seen;
        wait_cfg  = 0;
        rdata_cfg = 32'hDEAD_BEEF;
        exp_ops.push_back('{1'b0, 32'h1000_0004, 32'h0, 4'hF});
        exp_fill.push_back(32'hDEAD_BEEF);
        data_addr = 32'h1000_0004;
        read_en   = 1'b1;
        stall     = 1'b1;
        wait_fill(seen, n);
        stall   = 1'b0;
        read_en = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL read_miss_timeout no data_valid");
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL read_miss_latency got %0d need 3", n);
        end
        checks++;
        if (last_hold !== 1) begin
            errors++;
            $display("FAIL read_miss_hold mem_read %0d cycles need 1", last_hold);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0 || data_in !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_miss_after busy=%b dv=%b data_in=%h need 0 0 deadbeef",
                     busy, data_valid, data_in);
        end
        checks++;
        if (fill_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL read_miss_fills got %0d need 1", fill_cnt - f0);
        end
    endtask

    task automatic test_waitrequest();
        int f0 = fill_cnt;
        int n;
        int extra = 0;
        bit seen;
        wait_cfg  = 3;
        unstable  = 1'b0;
        rdata_cfg = 32'hA5A5_0001;
        exp_ops.push_back('{1'b0, 32'h2000_0010, 32'h0, 4'hF});
        exp_fill.push_back(32'hA5A5_0001);
        data_addr = 32'h2000_0013;
        read_en   = 1'b1;
        stall     = 1'b1;
        wait_fill(seen, n);
        stall   = 1'b0;
        read_en = 1'b0;
        checks++;
        if (!seen || last_hold !== 4) begin
            errors++;
            $display("FAIL wait_hold seen=%b mem_read %0d cycles need 4", seen, last_hold);
        end
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL wait_stable addr/be changed while waitrequest");
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (data_valid === 1'b1) extra++;
        end
        checks++;
        if (fill_cnt - f0 !== 1 || extra !== 0) begin
            errors++;
            $display("FAIL wait_fills got %0d extra %0d need 1 0", fill_cnt - f0, extra);
        end
        wait_cfg = 0;
    endtask

    task automatic test_write_hit();
        int w0 = wr_cnt;
        int bcnt = 0;
        bit done = 0;
        exp_ops.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0011});
        data_addr = 32'h0000_0020;
        writedata = 32'h1122_3344;
        byte_en   = 4'b0011;
        stall     = 1'b0;
        write_en  = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (wr_cnt != w0) write_en = 1'b0;
            if (busy === 1'b1) bcnt++;
            else if (wr_cnt != w0) done = 1'b1;
        end
        checks++;
        if (!done || wr_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL write_hit_ops got %0d writes need 1", wr_cnt - w0);
        end
        checks++;
        if (bcnt !== 1) begin
            errors++;
            $display("FAIL write_hit_busy got %0d cycles need 1", bcnt);
        end
    endtask

    task automatic test_write_miss();
        int  r0 = rd_cnt;
        int  w0 = wr_cnt;
        int  n;
        bit  seen;
        bit  wseen = 0;
        rdata_cfg = 32'h7777_0040;
        exp_ops.push_back('{1'b0, 32'h0000_0040, 32'h0, 4'hF});
        exp_ops.push_back('{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF});
        exp_fill.push_back(32'h7777_0040);
        data_addr = 32'h0000_0040;
        writedata = 32'hCAFE_F00D;
        byte_en   = 4'hF;
        read_en   = 1'b0;
        write_en  = 1'b1;
        stall     = 1'b1;
        wait_fill(seen, n);
        stall = 1'b0;
        for (int i = 0; i < 20 && !wseen; i++) begin
            tick();
            if (wr_cnt != w0) wseen = 1'b1;
        end
        write_en = 1'b0;
        tick();
        checks++;
        if (!seen || !wseen || rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL write_miss_ops reads=%0d writes=%0d need 1 1",
                     rd_cnt - r0, wr_cnt - w0);
        end
        checks++;
        if (exp_ops.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_miss_done pending=%0d busy=%b need 0 0",
                     exp_ops.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        int  f0 = fill_cnt;
        int  w0 = wr_cnt;
        int  n;
        bit  seen;
        bit  wseen = 0;
        logic [31:0] keep = data_in;
        inj_data   = 32'h5555_AAAA;
        inject_rdv = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (data_in !== keep || fill_cnt !== f0) begin
            errors++;
            $display("FAIL stray_rdv data_in=%h need %h", data_in, keep);
        end
        wait_cfg  = 2;
        rdata_cfg = 32'h1234_5678;
        exp_ops.push_back('{1'b0, 32'h0000_0080, 32'h0, 4'hF});
        exp_ops.push_back('{1'b1, 32'h0000_0084, 32'h0BAD_CAFE, 4'b1100});
        exp_fill.push_back(32'h1234_5678);
        data_addr = 32'h0000_0080;
        read_en   = 1'b1;
        stall     = 1'b1;
        tick();
        writedata = 32'hFFFF_0000;
        write_en  = 1'b1;
        tick();
        write_en = 1'b0;
        wait_fill(seen, n);
        stall     = 1'b0;
        read_en   = 1'b0;
        data_addr = 32'h0000_0084;
        writedata = 32'h0BAD_CAFE;
        byte_en   = 4'b1100;
        write_en  = 1'b1;
        for (int i = 0; i < 20 && !wseen; i++) begin
            tick();
            if (wr_cnt != w0) wseen = 1'b1;
        end
        write_en = 1'b0;
        tick();
        checks++;
        if (!seen || !wseen || wr_cnt - w0 !== 1 || exp_ops.size() !== 0) begin
            errors++;
            $display("FAIL back_to_back writes=%0d pending=%0d need 1 0",
                     wr_cnt - w0, exp_ops.size());
        end
        wait_cfg = 0;
    endtask

    task automatic test_watchdog();
        int f0 = fill_cnt;
        bit seen = 0;
        respond_en = 1'b0;
        exp_ops.push_back('{1'b0, 32'h0000_0300, 32'h0, 4'hF});
        data_addr = 32'h0000_0300;
        read_en   = 1'b1;
        stall     = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (err === 1'b1) seen = 1'b1;
        end
        stall   = 1'b0;
        read_en = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL watchdog_timeout err never set");
        end
        checks++;
        if (cyc - acc_cyc !== 5) begin
            errors++;
            $display("FAIL watchdog_delay err after %0d cycles need 5", cyc - acc_cyc);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || fill_cnt !== f0) begin
            errors++;
            $display("FAIL watchdog_after busy=%b err=%b fills=%0d need 0 1 0",
                     busy, err, fill_cnt - f0);
        end
    endtask

    task automatic test_rst_rd_wait();
        int  r0 = rd_cnt;
        int  dv = 0;
        int  n;
        bit  acc = 0;
        bit  seen;
        respond_en = 1'b0;
        exp_ops.push_back('{1'b0, 32'h0000_0500, 32'h0, 4'hF});
        data_addr = 32'h0000_0500;
        read_en   = 1'b1;
        stall     = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            tick();
            if (rd_cnt != r0) acc = 1'b1;
        end
        tick();
        rst     = 1'b1;
        stall   = 1'b0;
        read_en = 1'b0;
        tick();
        checks++;
        if (!acc || {data_in, data_valid, busy, err, bus.mem_read, bus.mem_write,
                     bus.mem_address, bus.mem_writedata, bus.mem_byteenable} !== '0) begin
            errors++;
            $display("FAIL rst_rd_wait acc=%b busy=%b err=%b rd=%b addr=%h need all 0",
                     acc, busy, err, bus.mem_read, bus.mem_address);
        end
        rst        = 1'b0;
        inj_data   = 32'hBAD0_BAD0;
        inject_rdv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (data_valid === 1'b1) dv++;
        end
        checks++;
        if (dv !== 0 || data_in !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL late_rdv dv=%0d data_in=%h busy=%b need 0 0 0", dv, data_in, busy);
        end
        respond_en = 1'b1;
        rdata_cfg  = 32'h0BAD_F00D;
        exp_ops.push_back('{1'b0, 32'h0000_0600, 32'h0, 4'hF});
        exp_fill.push_back(32'h0BAD_F00D);
        data_addr = 32'h0000_0600;
        read_en   = 1'b1;
        stall     = 1'b1;
        wait_fill(seen, n);
        stall   = 1'b0;
        read_en = 1'b0;
        tick();
        checks++;
        if (!seen || data_in !== 32'h0BAD_F00D || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_miss seen=%b data_in=%h need 0badf00d", seen, data_in);
        end
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        data_addr = '0;
        read_en   = 1'b0;
        write_en  = 1'b0;
        writedata = '0;
        byte_en   = '0;
        bus.mem_waitrequest   = 1'b0;
        bus.mem_readdata      = '0;
        bus.mem_readdatavalid = 1'b0;
        test_reset();
        test_read_miss();
        test_waitrequest();
        test_write_hit();
        test_write_miss();
        test_back_to_back();
        test_watchdog();
        test_rst_rd_wait();
        checks++;
        if (exp_ops.size() !== 0 || exp_fill.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_leftover ops=%0d fills=%0d need 0 0",
                     exp_ops.size(), exp_fill.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
